// File: rtl/mem_block_responder.sv
// mem_block_responder: single-port line responder for a cache refill /
// write-back pair. Write-backs are serviced before a coincident refill so a
// refill of the same line observes the freshly written data.
module mem_block_responder #(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         fill_req,
    input  logic [31:0]  fill_addr,
    input  logic         wb_req,
    input  logic [31:0]  wb_addr,
    input  logic [127:0] wb_data,
    output logic [127:0] fill_data,
    output logic         fill_valid,
    output logic         wb_done,
    output logic         busy,
    output logic         err
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
    localparam logic [31:0] IO_LIM = 32'h1100_0000;

    typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

    state_t         state_q, state_n;
    logic [3:0]     cnt_q, cnt_n;
    logic [1:0]     beat_q, beat_n;
    logic           pend_q, pend_n;
    logic [31:0]    faddr_q, faddr_n;
    logic [31:0]    waddr_q, waddr_n;
    logic [127:0]   wdata_q, wdata_n;
    logic [95:0]    shadow_q, shadow_n;
    logic [127:0]   fill_data_n;
    logic           fill_valid_n, wb_done_n, busy_n, err_n;

    logic                  fill_ok, wb_ok;
    logic [31:0]           addr_sel;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_idx;
    logic [31:0]           mem_wword;
    logic [31:0]           mem_rword;

    // Backing store starts zeroed and is never touched by RESET.
    logic [31:0] mem [DEPTH] = '{default: '0};

    assign fill_ok   = fill_req && (fill_addr < IO_LIM);
    assign wb_ok     = wb_req && (wb_addr < IO_LIM);
    assign addr_sel  = (state_q == WB) ? waddr_q : faddr_q;
    assign mem_idx   = {addr_sel[DEPTH_LOG2+1:4], beat_q};
    assign mem_rword = mem[mem_idx];

    // Backing-store write port; a write coinciding with RESET is dropped.
    always_ff @(posedge CLK) begin
        if (mem_we && !RESET) begin
            mem[mem_idx] <= mem_wword;
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_n      = state_q;
        cnt_n        = cnt_q;
        beat_n       = beat_q;
        pend_n       = pend_q;
        faddr_n      = faddr_q;
        waddr_n      = waddr_q;
        wdata_n      = wdata_q;
        shadow_n     = shadow_q;
        fill_data_n  = fill_data;
        fill_valid_n = 1'b0;
        wb_done_n    = 1'b0;
        err_n        = 1'b0;
        mem_we       = 1'b0;

        case (beat_q)
            2'd0:    mem_wword = wdata_q[127:96];
            2'd1:    mem_wword = wdata_q[95:64];
            2'd2:    mem_wword = wdata_q[63:32];
            default: mem_wword = wdata_q[31:0];
        endcase

        case (state_q)
            IDLE: begin
                err_n   = (fill_req && !fill_ok) || (wb_req && !wb_ok);
                faddr_n = fill_addr;
                waddr_n = wb_addr;
                wdata_n = wb_data;
                cnt_n   = LAT_M1;
                beat_n  = 2'd0;
                if (wb_ok) begin
                    state_n = WB;
                    pend_n  = fill_ok;
                end else if (fill_ok) begin
                    state_n = FILL;
                    pend_n  = 1'b0;
                end
            end
            WB: begin
                if (cnt_q == 4'd0) begin
                    mem_we = 1'b1;
                    cnt_n  = LAT_M1;
                    beat_n = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        wb_done_n = 1'b1;
                        state_n   = pend_q ? FILL : IDLE;
                        pend_n    = 1'b0;
                    end
                end else begin
                    cnt_n = cnt_q - 4'd1;
                end
            end
            FILL: begin
                if (cnt_q == 4'd0) begin
                    cnt_n  = LAT_M1;
                    beat_n = beat_q + 2'd1;
                    case (beat_q)
                        2'd0: shadow_n[95:64] = mem_rword;
                        2'd1: shadow_n[63:32] = mem_rword;
                        2'd2: shadow_n[31:0]  = mem_rword;
                        default: begin
                            // Line is published in one step so fill_data never shows a partial line.
                            fill_data_n  = {shadow_q, mem_rword};
                            fill_valid_n = 1'b1;
                            state_n      = DONE;
                        end
                    endcase
                end else begin
                    cnt_n = cnt_q - 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            beat_q     <= '0;
            pend_q     <= 1'b0;
            fill_data  <= '0;
            fill_valid <= 1'b0;
            wb_done    <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            beat_q     <= beat_n;
            pend_q     <= pend_n;
            fill_data  <= fill_data_n;
            fill_valid <= fill_valid_n;
            wb_done    <= wb_done_n;
            busy       <= busy_n;
            err        <= err_n;
        end
        faddr_q  <= faddr_n;
        waddr_q  <= waddr_n;
        wdata_q  <= wdata_n;
        shadow_q <= shadow_n;
    end

endmodule

// File: tb/tb_mem_block_responder.sv
// Directed bench for mem_block_responder (LATENCY=2, DEPTH_LOG2=12).
module tb_mem_block_responder;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         fill_req = 1'b0;
    logic [31:0]  fill_addr = '0;
    logic         wb_req = 1'b0;
    logic [31:0]  wb_addr = '0;
    logic [127:0] wb_data = '0;
    logic [127:0] fill_data;
    logic         fill_valid, wb_done, busy, err;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0]  IO_LIM = 32'h1100_0000;
    localparam logic [127:0] L_ABCD = 128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333;
    localparam logic [127:0] L_X    = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] L_Y    = 128'h11112222_33334444_55556666_77778888;
    localparam logic [127:0] L_W    = 128'hCAFEF00D_DEADBEEF_0BADC0DE_FEEDFACE;
    localparam logic [127:0] L_Z    = 128'h5A5A5A5A_A5A5A5A5_3C3C3C3C_C3C3C3C3;
    localparam logic [127:0] L_V    = 128'h00000001_00000002_00000003_00000004;
    localparam logic [127:0] L_EFGH = 128'hEEEE0001_FFFF0002_99990003_88880004;
    localparam logic [127:0] L_JUNK = 128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0;

    mem_block_responder #(.LATENCY(2), .DEPTH_LOG2(12)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .fill_req   (fill_req),
        .fill_addr  (fill_addr),
        .wb_req     (wb_req),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .fill_data  (fill_data),
        .fill_valid (fill_valid),
        .wb_done    (wb_done),
        .busy       (busy),
        .err        (err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string        name;
        logic         wb;
        logic [31:0]  wa;
        logic [127:0] wd;
        logic         fill;
        logic [31:0]  fa;
        int           e_err;   // cycle after acceptance edge of err pulse, 0 = none
        int           e_wb;    // cycle of wb_done pulse, 0 = none
        int           e_fv;    // cycle of fill_valid pulse, 0 = none
        logic [127:0] e_fd;
        int           e_busy;  // number of consecutive busy cycles from cycle 1
    } vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic wb, input logic [31:0] wa,
                                input logic [127:0] wd, input logic fill, input logic [31:0] fa,
                                input int e_err, input int e_wb, input int e_fv,
                                input logic [127:0] e_fd, input int e_busy);
        vec_t v;
        v.name = name; v.wb = wb; v.wa = wa; v.wd = wd; v.fill = fill; v.fa = fa;
        v.e_err = e_err; v.e_wb = e_wb; v.e_fv = e_fv; v.e_fd = e_fd; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int   f_err = 0, f_wb = 0, f_fv = 0, c_err = 0, c_wb = 0, c_fv = 0;
        int   bcnt = 0, fidle = 0;
        logic [127:0] fd = '0;
        logic wb_bad, fill_bad;
        wb_bad   = v.wa >= IO_LIM;
        fill_bad = v.fa >= IO_LIM;
        @(negedge CLK);
        wb_req = v.wb; wb_addr = v.wa; wb_data = v.wd;
        fill_req = v.fill; fill_addr = v.fa;
        for (int n = 1; n <= 24; n++) begin
            @(negedge CLK);
            if (err) begin
                c_err++;
                if (f_err == 0) f_err = n;
                if (wb_bad) wb_req = 1'b0;
                if (fill_bad) fill_req = 1'b0;
            end
            if (wb_done) begin
                c_wb++;
                if (f_wb == 0) f_wb = n;
                wb_req = 1'b0;
            end
            if (fill_valid) begin
                c_fv++;
                if (f_fv == 0) begin
                    f_fv = n;
                    fd = fill_data;
                end
                fill_req = 1'b0;
            end
            if (busy) bcnt++;
            else if (fidle == 0) fidle = n;
        end
        check({v.name, " err_cycle"},  128'(f_err), 128'(v.e_err));
        check({v.name, " err_count"},  128'(c_err), 128'(v.e_err != 0 ? 1 : 0));
        check({v.name, " wb_cycle"},   128'(f_wb),  128'(v.e_wb));
        check({v.name, " wb_count"},   128'(c_wb),  128'(v.e_wb != 0 ? 1 : 0));
        check({v.name, " fv_cycle"},   128'(f_fv),  128'(v.e_fv));
        check({v.name, " fv_count"},   128'(c_fv),  128'(v.e_fv != 0 ? 1 : 0));
        check({v.name, " busy_cnt"},   128'(bcnt),  128'(v.e_busy));
        check({v.name, " busy_drop"},  128'(fidle), 128'(v.e_busy + 1));
        if (v.e_fv != 0) begin
            check({v.name, " fill_data"},      fd,        v.e_fd);
            check({v.name, " fill_data_hold"}, fill_data, v.e_fd);
        end
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = mk("wb_40",        1, 32'h40,       L_ABCD, 0, 32'h0,        0, 9, 0,  '0,     8);
        vecs[1]  = mk("fill_4C",      0, 32'h0,        '0,     1, 32'h4C,       0, 0, 9,  L_ABCD, 9);
        vecs[2]  = mk("wb_fill_100",  1, 32'h100,      L_X,    1, 32'h100,      0, 9, 17, L_X,    17);
        vecs[3]  = mk("fill_io",      0, 32'h0,        '0,     1, 32'h1100_0000,1, 0, 0,  '0,     0);
        vecs[4]  = mk("wb_4000",      1, 32'h4000,     L_Y,    0, 32'h0,        0, 9, 0,  '0,     8);
        vecs[5]  = mk("fill_wrap_0",  0, 32'h0,        '0,     1, 32'h0,        0, 0, 9,  L_Y,    9);
        vecs[6]  = mk("wbio_fill_40", 1, 32'h1100_0000,L_JUNK, 1, 32'h40,       1, 0, 9,  L_ABCD, 9);
        vecs[7]  = mk("wb500_fillio", 1, 32'h500,      L_W,    1, 32'h1234_5670,1, 9, 0,  '0,     8);
        vecs[8]  = mk("fill_500",     0, 32'h0,        '0,     1, 32'h500,      0, 0, 9,  L_W,    9);
        vecs[9]  = mk("fill_unwr",    0, 32'h0,        '0,     1, 32'h800,      0, 0, 9,  '0,     9);
        vecs[10] = mk("wb_200",       1, 32'h200,      L_Z,    0, 32'h0,        0, 9, 0,  '0,     8);
        vecs[11] = mk("wb_below_io",  1, 32'h10FF_FFF0,L_V,    0, 32'h0,        0, 9, 0,  '0,     8);
        vecs[12] = mk("fill_3FF0",    0, 32'h0,        '0,     1, 32'h3FF0,     0, 0, 9,  L_V,    9);

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst busy",       128'(busy),       '0);
        check("rst err",        128'(err),        '0);
        check("rst fill_valid", 128'(fill_valid), '0);
        check("rst wb_done",    128'(wb_done),    '0);
        check("rst fill_data",  fill_data,        '0);
        RESET = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(vecs[i]);

        // Fill request held across completion is re-accepted with the new address.
        begin
            int c_fv = 0;
            @(negedge CLK);
            fill_req = 1'b1; fill_addr = 32'h40;
            for (int n = 1; n <= 24; n++) begin
                @(negedge CLK);
                if (fill_valid) c_fv++;
                if (n == 1) fill_addr = 32'h200;
                if (n == 9) begin
                    check("hold fv1",   128'(fill_valid), 128'(1));
                    check("hold data1", fill_data,        L_ABCD);
                end
                if (n == 10) check("hold idle", 128'(busy), 128'(0));
                if (n == 11) begin
                    check("hold rebusy", 128'(busy), 128'(1));
                    fill_req = 1'b0;
                end
                if (n == 14) check("hold data_stable", fill_data, L_ABCD);
                if (n == 19) begin
                    check("hold fv2",   128'(fill_valid), 128'(1));
                    check("hold data2", fill_data,        L_Z);
                end
            end
            check("hold fv_count", 128'(c_fv), 128'(2));
        end

        // RESET mid write-back: beat 0 survives, no completion pulse.
        begin
            int c_wb = 0;
            @(negedge CLK);
            wb_req = 1'b1; wb_addr = 32'h300; wb_data = L_EFGH;
            for (int n = 1; n <= 20; n++) begin
                @(negedge CLK);
                if (wb_done) c_wb++;
                if (n == 3) begin
                    RESET = 1'b1;
                    wb_req = 1'b0;
                end
                if (n == 4) begin
                    check("midrst busy",      128'(busy), 128'(0));
                    check("midrst fill_data", fill_data,  '0);
                    RESET = 1'b0;
                end
            end
            check("midrst wb_count", 128'(c_wb), 128'(0));
            run_vec(mk("fill_300", 0, 32'h0, '0, 1, 32'h300, 0, 0, 9,
                       128'hEEEE0001_00000000_00000000_00000000, 9));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_block_responder.md
MEM_BLOCK_RESPONDER -- requirements
Module: mem_block_responder

Interface
REQ-001 SHALL have parameter: LATENCY, 2, clock cycles per word beat (legal range 1..15).
REQ-002 SHALL have parameter: DEPTH_LOG2, 12, log2 of backing-store depth in 32-bit words (4096 words = 16 KiB).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: CLK  in  1  rising-edge clock.
REQ-005 SHALL have port: RESET  in  1  synchronous active-high reset.
REQ-006 SHALL have port: fill_req  in  1  line refill request, level, held until fill_valid or err.
REQ-007 SHALL have port: fill_addr  in  32  refill byte address; bits [3:0] ignored.
REQ-008 SHALL have port: wb_req  in  1  dirty-line write-back request, level, held until wb_done or err.
REQ-009 SHALL have port: wb_addr  in  32  write-back byte address; bits [3:0] ignored.
REQ-010 SHALL have port: wb_data  in  128  write-back line; [127:96] = word 0, [31:0] = word 3.
REQ-011 SHALL have port: fill_data  out  128  refilled line, same word order as wb_data.
REQ-012 SHALL have port: fill_valid  out  1  one-cycle pulse, fill_data complete.
REQ-013 SHALL have port: wb_done  out  1  one-cycle pulse, write-back line committed.
REQ-014 SHALL have port: busy  out  1  high whenever state is not IDLE.
REQ-015 SHALL have port: err  out  1  one-cycle pulse, request rejected (I/O address).

Function
REQ-016 SHALL implement FSM states IDLE, WB, FILL, DONE; all outputs registered.
REQ-017 In IDLE, SHALL accept requests at edge T0: latch addresses, wb_data, pend_fill = fill_req; go to WB if wb_req, else FILL if fill_req.
REQ-018 SHALL reject any request whose address >= 32'h11000000: no acceptance, err high for the cycle after T0; a valid partner request in the same cycle is still accepted.
REQ-019 SHALL perform 4 beats, word 0 first; beat k transfers at edge T0 + (k+1)*LATENCY, using a LATENCY-1 down-counter and a 2-bit beat counter.
REQ-020 SHALL compute word index as {addr[DEPTH_LOG2+1:4], beat}; higher address bits ignored (aliasing/wrap).
REQ-021 WB SHALL write one latched word per beat; after beat 3 SHALL pulse wb_done for one cycle and go to FILL if pend_fill, else IDLE.
REQ-022 FILL SHALL read one word per beat into a shadow register; after beat 3 SHALL load fill_data with the full line and enter DONE.
REQ-023 DONE SHALL assert fill_valid for exactly one cycle, then return to IDLE; fill_data SHALL never show a partial line and SHALL hold until the next completed fill.
REQ-024 On simultaneous wb_req and fill_req, SHALL service WB first, so a fill to the same line returns the written-back data.
REQ-025 SHALL ignore requests while busy; a request still high on return to IDLE SHALL be accepted again (requester deasserts on pulse).
REQ-026 Backing store SHALL initialize to all zero at time 0 and SHALL NOT be cleared by RESET.

Reset
REQ-027 RESET SHALL force state IDLE, counters 0, fill_data 0, fill_valid 0, wb_done 0, busy 0, err 0 on the next edge.
REQ-028 RESET mid-transfer SHALL abandon it; words already written SHALL remain, no done/valid pulse SHALL issue.

Verification
REQ-029 LATENCY=2: wb 0x40 data {A,B,C,D} accepted T0 -> wb_done in cycle after T0+8; then fill 0x4C -> fill_data={A,B,C,D}, fill_valid 8 cycles after acceptance.
REQ-030 Simultaneous wb 0x100 data X and fill 0x100 at T0 -> wb_done after T0+8, fill_valid after T0+16 with fill_data=X, busy continuous.
REQ-031 fill 0x200 asserted while busy with another fill -> not accepted until IDLE; then served normally.
REQ-032 fill_req with address 0x11000000 -> err one cycle, busy stays 0, no fill_valid.
REQ-033 RESET at T0+3 during wb 0x300 {E,F,G,H} over zero memory -> busy 0 next cycle, no wb_done; later fill 0x300 returns {E,0,0,0}.
REQ-034 wb 0x4000 data Y, then fill 0x0 (DEPTH_LOG2=12) -> fill_data=Y (address wrap).
